// File: rtl/mycpu_pkg.sv
// Shared types and constants for the datapath steering blocks.
package mycpu_pkg;

   localparam int DATA_W         = 16;
   localparam int DEMUX_CHANNELS = 3;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [1:0]        demux_sel_t;

   // Select code 3 has no destination; transfers to it are sunk and counted.
   localparam demux_sel_t SEL_ILLEGAL = 2'd3;

endpackage

// File: rtl/demux_3x16_slot.sv
// One-entry channel buffer. A load wins over a same-cycle drain, so a full
// slot can be refilled in the cycle it empties without a bubble.
module demux_3x16_slot #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_in,
   input  logic [W-1:0] data_in,
   input  logic         drain_in,
   output logic [W-1:0] q_out,
   output logic         v_out
);

   // Buffer register: load replaces the word, drain only clears the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_out <= 1'b0;
         q_out <= '0;
      end else if (load_in) begin
         v_out <= 1'b1;
         q_out <= data_in;
      end else if (drain_in) begin
         v_out <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_3x16.sv
// Three-way demultiplexer: steers one source word into one of three
// single-entry channel buffers, sinking and counting illegal selects.
module demux_3x16 #(
   parameter int DATA_W     = mycpu_pkg::DATA_W,
   parameter int DROP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            sel_in,
   input  logic [DATA_W-1:0]     d_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [DATA_W-1:0]     q0_out,
   output logic [DATA_W-1:0]     q1_out,
   output logic [DATA_W-1:0]     q2_out,
   output logic                  v0_out,
   output logic                  v1_out,
   output logic                  v2_out,
   input  logic                  r0_in,
   input  logic                  r1_in,
   input  logic                  r2_in,
   output logic                  err_out,
   output logic [DROP_CNT_W-1:0] drop_cnt_out,
   input  logic                  clr_in
);

   import mycpu_pkg::*;

   logic [DEMUX_CHANNELS-1:0] v;
   logic [DEMUX_CHANNELS-1:0] r;
   logic [DEMUX_CHANNELS-1:0] load;
   logic [DEMUX_CHANNELS-1:0] drain;
   logic [DATA_W-1:0]         q [DEMUX_CHANNELS];
   logic                      xfer;
   logic                      illegal_xfer;

   assign r = {r2_in, r1_in, r0_in};

   // Ready depends only on the addressed slot (or the sink), never on valid_in.
   always_comb begin
      ready_out = 1'b0;
      if (rst_n) begin
         case (sel_in)
            2'd0:    ready_out = !v[0] | r[0];
            2'd1:    ready_out = !v[1] | r[1];
            2'd2:    ready_out = !v[2] | r[2];
            default: ready_out = 1'b1;
         endcase
      end
   end

   assign xfer         = valid_in & ready_out;
   assign illegal_xfer = xfer & (sel_in == SEL_ILLEGAL);

   for (genvar i = 0; i < DEMUX_CHANNELS; i++) begin : g_slot
      assign load[i]  = xfer & (sel_in == demux_sel_t'(i));
      assign drain[i] = v[i] & r[i];

      demux_3x16_slot #(.W(DATA_W)) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_in  (load[i]),
         .data_in  (d_in),
         .drain_in (drain[i]),
         .q_out    (q[i]),
         .v_out    (v[i])
      );
   end

   assign q0_out = q[0];
   assign q1_out = q[1];
   assign q2_out = q[2];
   assign v0_out = v[0];
   assign v1_out = v[1];
   assign v2_out = v[2];

   // Sticky error and saturating drop counter; clear beats a same-cycle drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_out      <= 1'b0;
         drop_cnt_out <= '0;
      end else if (clr_in) begin
         err_out      <= 1'b0;
         drop_cnt_out <= '0;
      end else if (illegal_xfer) begin
         err_out <= 1'b1;
         if (drop_cnt_out != '1) begin
            drop_cnt_out <= drop_cnt_out + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_demux_3x16.sv
module tb_demux_3x16;

   logic        clk;
   logic        rst_n;
   logic [1:0]  sel_in;
   logic [15:0] d_in;
   logic        valid_in;
   logic        ready_out;
   logic [15:0] q0_out, q1_out, q2_out;
   logic        v0_out, v1_out, v2_out;
   logic [2:0]  r_in;
   logic        err_out;
   logic [7:0]  drop_cnt_out;
   logic        clr_in;

   int errors = 0;
   int checks = 0;

   // reference model: channel contents, error flag, drop count
   bit        m_v [3];
   bit [15:0] m_q [3];
   bit        m_err;
   int        m_cnt;

   demux_3x16 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sel_in       (sel_in),
      .d_in         (d_in),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .q0_out       (q0_out),
      .q1_out       (q1_out),
      .q2_out       (q2_out),
      .v0_out       (v0_out),
      .v1_out       (v1_out),
      .v2_out       (v2_out),
      .r0_in        (r_in[0]),
      .r1_in        (r_in[1]),
      .r2_in        (r_in[2]),
      .err_out      (err_out),
      .drop_cnt_out (drop_cnt_out),
      .clr_in       (clr_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   a_q0_hold: assert property (@(posedge clk) disable iff (!rst_n) (v0_out && !r_in[0]) |=> $stable(q0_out));
   a_q1_hold: assert property (@(posedge clk) disable iff (!rst_n) (v1_out && !r_in[1]) |=> $stable(q1_out));
   a_q2_hold: assert property (@(posedge clk) disable iff (!rst_n) (v2_out && !r_in[2]) |=> $stable(q2_out));
   a_v_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({v0_out, v1_out, v2_out}));
   a_cnt_mono: assert property (@(posedge clk) disable iff (!rst_n) !clr_in |=> (drop_cnt_out >= $past(drop_cnt_out)));

   function automatic bit dut_v(int n);
      return (n == 0) ? v0_out : (n == 1) ? v1_out : v2_out;
   endfunction

   function automatic logic [15:0] dut_q(int n);
      return (n == 0) ? q0_out : (n == 1) ? q1_out : q2_out;
   endfunction

   // A destination can take a word if it is empty or being emptied now.
   function automatic bit model_ready();
      if (!rst_n) return 1'b0;
      if (sel_in == 2'd3) return 1'b1;
      return !m_v[sel_in] || r_in[sel_in];
   endfunction

   task automatic model_reset();
      for (int n = 0; n < 3; n++) begin
         m_v[n] = 1'b0;
         m_q[n] = '0;
      end
      m_err = 1'b0;
      m_cnt = 0;
   endtask

   // Advance one clock and apply the cycle's effect to the model.
   task automatic tick();
      bit        nv [3];
      bit [15:0] nq [3];
      bit        xfer;
      bit        nerr;
      int        ncnt;
      xfer = valid_in && model_ready();
      for (int n = 0; n < 3; n++) begin
         nv[n] = m_v[n];
         nq[n] = m_q[n];
         if (m_v[n] && r_in[n]) nv[n] = 1'b0;
         if (xfer && sel_in == n[1:0]) begin
            nv[n] = 1'b1;
            nq[n] = d_in;
         end
      end
      nerr = m_err;
      ncnt = m_cnt;
      if (clr_in) begin
         nerr = 1'b0;
         ncnt = 0;
      end else if (xfer && sel_in == 2'd3) begin
         nerr = 1'b1;
         ncnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int n = 0; n < 3; n++) begin
            m_v[n] = nv[n];
            m_q[n] = nq[n];
         end
         m_err = nerr;
         m_cnt = ncnt;
      end
   endtask

   task automatic idle_inputs();
      sel_in   = 2'd0;
      d_in     = '0;
      valid_in = 1'b0;
      r_in     = 3'b000;
      clr_in   = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      valid_in = 1'b1;
      sel_in = 2'd3;
      model_reset();
      #1;
      checks++;
      if (ready_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b want 0", ready_out);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_inputs();
      #1;
      checks++;
      if ({v2_out, v1_out, v0_out} !== 3'b000) begin
         errors++;
         $display("FAIL reset_valids: got %b want 000", {v2_out, v1_out, v0_out});
      end
      checks++;
      if ({q0_out, q1_out, q2_out} !== 48'h0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0", {q0_out, q1_out, q2_out});
      end
      checks++;
      if (err_out !== 1'b0 || drop_cnt_out !== 8'd0) begin
         errors++;
         $display("FAIL reset_err_cnt: got err=%b cnt=%0d want err=0 cnt=0", err_out, drop_cnt_out);
      end
   endtask

   task automatic test_single_accept();
      valid_in = 1'b1;
      sel_in   = 2'd1;
      d_in     = 16'hA5A5;
      r_in     = 3'b000;
      #1;
      checks++;
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready: got %b want 1", ready_out);
      end
      tick();
      checks++;
      if (v1_out !== 1'b1 || q1_out !== 16'hA5A5 || v0_out !== 1'b0 || v2_out !== 1'b0) begin
         errors++;
         $display("FAIL accept_load: got v=%b q1=%h want v=010 q1=a5a5", {v2_out, v1_out, v0_out}, q1_out);
      end
      d_in = 16'h5A5A;
      #1;
      checks++;
      if (ready_out !== 1'b0) begin
         errors++;
         $display("FAIL accept_full_stall: got %b want 0", ready_out);
      end
      tick();
      checks++;
      if (q1_out !== 16'hA5A5) begin
         errors++;
         $display("FAIL accept_hold: got %h want a5a5", q1_out);
      end
   endtask

   task automatic test_drain_and_load();
      valid_in = 1'b1;
      sel_in   = 2'd1;
      d_in     = 16'h1234;
      r_in     = 3'b010;
      #1;
      checks++;
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL passthru_ready: got %b want 1", ready_out);
      end
      tick();
      checks++;
      if (v1_out !== 1'b1 || q1_out !== 16'h1234) begin
         errors++;
         $display("FAIL passthru_data: got v1=%b q1=%h want v1=1 q1=1234", v1_out, q1_out);
      end
      valid_in = 1'b0;
      r_in     = 3'b111;
      tick();
      checks++;
      if ({v2_out, v1_out, v0_out} !== 3'b000 || q1_out !== 16'h1234) begin
         errors++;
         $display("FAIL drain_keeps_q: got v=%b q1=%h want v=000 q1=1234", {v2_out, v1_out, v0_out}, q1_out);
      end
   endtask

   task automatic test_back_to_back();
      r_in     = 3'b000;
      valid_in = 1'b1;
      for (int n = 0; n < 3; n++) begin
         sel_in = n[1:0];
         d_in   = 16'(n + 1);
         #1;
         checks++;
         if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready%0d: got %b want 1", n, ready_out);
         end
         tick();
      end
      for (int n = 0; n < 3; n++) begin
         checks++;
         if (dut_v(n) !== 1'b1 || dut_q(n) !== 16'(n + 1)) begin
            errors++;
            $display("FAIL b2b_chan%0d: got v=%b q=%h want v=1 q=%h", n, dut_v(n), dut_q(n), 16'(n + 1));
         end
      end
      sel_in = 2'd0;
      d_in   = 16'h0004;
      #1;
      checks++;
      if (ready_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stall: got %b want 0", ready_out);
      end
      tick();
   endtask

   task automatic test_illegal_saturate();
      int bad_ready = 0;
      int bad_chan  = 0;
      valid_in = 1'b1;
      sel_in   = 2'd3;
      r_in     = 3'b000;
      for (int i = 0; i < 300; i++) begin
         d_in = 16'($urandom);
         #1;
         if (ready_out !== 1'b1) bad_ready++;
         tick();
         if (i == 0) begin
            checks++;
            if (err_out !== 1'b1 || drop_cnt_out !== 8'd1) begin
               errors++;
               $display("FAIL illegal_first: got err=%b cnt=%0d want err=1 cnt=1", err_out, drop_cnt_out);
            end
         end
         for (int n = 0; n < 3; n++)
            if (dut_v(n) !== m_v[n] || dut_q(n) !== m_q[n]) bad_chan++;
      end
      checks++;
      if (bad_ready != 0) begin
         errors++;
         $display("FAIL illegal_ready: got %0d stalled cycles want 0", bad_ready);
      end
      checks++;
      if (bad_chan != 0) begin
         errors++;
         $display("FAIL illegal_chan: got %0d channel changes want 0", bad_chan);
      end
      checks++;
      if (err_out !== 1'b1 || drop_cnt_out !== 8'd255) begin
         errors++;
         $display("FAIL illegal_sat: got err=%b cnt=%0d want err=1 cnt=255", err_out, drop_cnt_out);
      end
   endtask

   task automatic test_clear_priority();
      valid_in = 1'b1;
      sel_in   = 2'd3;
      clr_in   = 1'b1;
      tick();
      clr_in   = 1'b0;
      valid_in = 1'b0;
      checks++;
      if (err_out !== 1'b0 || drop_cnt_out !== 8'd0) begin
         errors++;
         $display("FAIL clr_priority: got err=%b cnt=%0d want err=0 cnt=0", err_out, drop_cnt_out);
      end
   endtask

   task automatic test_async_reset();
      valid_in = 1'b0;
      r_in     = 3'b000;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({v2_out, v1_out, v0_out} !== 3'b000 || {q0_out, q1_out, q2_out} !== 48'h0 || ready_out !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got v=%b q=%h rdy=%b want all 0", {v2_out, v1_out, v0_out}, {q0_out, q1_out, q2_out}, ready_out);
      end
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      valid_in = 1'b1;
      sel_in   = 2'd2;
      d_in     = 16'hBEEF;
      tick();
      valid_in = 1'b0;
      checks++;
      if (v2_out !== 1'b1 || q2_out !== 16'hBEEF || v0_out !== 1'b0 || v1_out !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_accept: got v=%b q2=%h want v=100 q2=beef", {v2_out, v1_out, v0_out}, q2_out);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 3000; i++) begin
         sel_in   = 2'($urandom_range(0, 3));
         d_in     = 16'($urandom);
         valid_in = ($urandom_range(0, 3) != 0);
         r_in     = 3'($urandom);
         clr_in   = ($urandom_range(0, 31) == 0);
         #1;
         checks++;
         if (ready_out !== model_ready()) begin
            errors++;
            bad++;
            if (bad < 10) $display("FAIL rand_ready @%0d: got %b want %b", i, ready_out, model_ready());
         end
         tick();
         for (int n = 0; n < 3; n++) begin
            checks++;
            if (dut_v(n) !== m_v[n] || dut_q(n) !== m_q[n]) begin
               errors++;
               bad++;
               if (bad < 10) $display("FAIL rand_chan%0d @%0d: got v=%b q=%h want v=%b q=%h", n, i, dut_v(n), dut_q(n), m_v[n], m_q[n]);
            end
         end
         checks++;
         if (err_out !== m_err || drop_cnt_out !== 8'(m_cnt)) begin
            errors++;
            bad++;
            if (bad < 10) $display("FAIL rand_err @%0d: got err=%b cnt=%0d want err=%b cnt=%0d", i, err_out, drop_cnt_out, m_err, m_cnt);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single_accept();
      test_drain_and_load();
      test_back_to_back();
      test_illegal_saturate();
      test_clear_priority();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux_3x16.md
Name: demux_3x16

Overview:
- Three-way 16-bit demultiplexer with one-entry output buffering and a valid/ready handshake on every side.
- It is the distributing counterpart of mux_3x16: a single 16-bit source (e.g. ALU/write-back bus) is steered by a 2-bit select into one of three destination channels.
- Each channel holds one word until its consumer accepts it.
- Illegal selects are dropped, flagged and counted.

Parameters:
- DATA_W, 16, width of data path and of every channel buffer.
- DROP_CNT_W, 8, width of the saturating dropped-transfer counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- sel_in  in  2  destination select: 0,1,2 valid; 3 illegal
- d_in  in  DATA_W  source data
- valid_in  in  1  source offers d_in/sel_in this cycle
- ready_out  out  1  demux accepts this cycle (transfer = valid_in & ready_out)
- q0_out, q1_out, q2_out  out  DATA_W each  channel buffer contents
- v0_out, v1_out, v2_out  out  1 each  channel buffer full
- r0_in, r1_in, r2_in  in  1 each  channel consumer ready (drain = vN_out & rN_in)
- err_out  out  1  sticky: an illegal select was accepted
- drop_cnt_out  out  DROP_CNT_W  number of illegal-select transfers, saturating
- clr_in  in  1  synchronous clear of err_out and drop_cnt_out

Behaviour:
- Reset (async assert, sync-to-clk deassert by upstream):
  - all vN_out=0, qN_out=0, err_out=0, drop_cnt_out=0.
  - ready_out=0 while rst_n=0.
- ready_out (combinational):
  - sel_in in 0..2: ready_out = !vN_out | rN_in for N=sel_in.
  - sel_in=3: ready_out=1 (sink).
  - ready_out does not depend on valid_in.
- Accept on legal sel N: next cycle vN_out=1 and qN_out=d_in. Latency is 1 clock from transfer to vN_out.
- Drain on channel N with no new accept to N: next cycle vN_out=0 and qN_out holds its last value (not cleared).
- Simultaneous drain and accept on the same channel: vN_out stays 1, qN_out is replaced by d_in. No bubble, no loss.
- Channels are independent: drains on other channels in the same cycle as an accept are all honoured.
- Full channel with rN_in=0 and sel_in=N: ready_out=0, the source must hold. Other channels keep draining.
- Illegal sel=3 transfer:
  - no channel changes, data discarded.
  - err_out set next cycle.
  - drop_cnt_out increments next cycle, saturating at all-ones (255 for default).
- clr_in=1: err_out=0 and drop_cnt_out=0 next cycle. clr_in has priority over a same-cycle illegal transfer, which is then not counted.
- Reset mid-operation: buffered words are lost, all valids drop immediately (async).
- vN_out/qN_out are registered outputs with no combinational path from inputs.
- Assertions (bound via the SVA bind file):
  - qN_out stable while vN_out & !rN_in.
  - vN_out never X after reset.
  - drop_cnt_out never decrements except on clr_in.

Decomposition:
- mycpu_pkg gains:
  - DEMUX_CHANNELS=3
  - typedef logic [1:0] demux_sel_t
  - constant SEL_ILLEGAL=2'd3
  - typedef logic [DATA_W-1:0] word_t (if not already present).
- Sub-module demux_slot: one-entry buffer with load/drain/full, ports clk, rst_n, load_in, data_in, drain_in, q_out, v_out. Instantiated three times.
- The top level contains sel decode, ready generation, and the error/counter logic.

Test Plan:
- Reset, then valid_in=1, sel=1, d_in=16'hA5A5, r1_in=0 -> next cycle v1_out=1, q1_out=A5A5, v0/v2=0. Next word to sel=1 sees ready_out=0.
- Channel 1 full, r1_in=1, new word 16'h1234 to sel=1 in the same cycle -> ready_out=1. Next cycle v1_out=1, q1_out=1234.
- Back-to-back words 0x0001, 0x0002, 0x0003 to sel 0, 1, 2 on consecutive cycles, all rN_in=0 -> all three valids 1, queues hold those values, 4th word to sel=0 stalls.
- 300 consecutive transfers with sel=3 -> all ready_out=1, no channel change, err_out=1 after the first, drop_cnt_out=255 (saturated).
- clr_in=1 in the same cycle as a sel=3 transfer -> next cycle err_out=0, drop_cnt_out=0.
- rst_n dropped asynchronously mid-cycle with all channels full -> all vN_out=0 and qN_out=0 before the next clk edge. After release, normal accept resumes.
